pipa_cell_request: RTL
======================

Name: pipa_cell_request

Overview:
- Consumes the gated PIPA pulse outputs (PIPGXp, PIPGXm, PIPGYp, PIPGYm, PIPGZp, PIPGZm) produced by the PIPA gating logic in the A9-family modules.
- Converts each pulse into a pending counter-cell increment or decrement request for the X, Y or Z PIPA counter.
- Serialises those requests to the counter priority chain over a REQ/GNT handshake, one request at a time.
- Sits between the PIPA gating stage and the counter-increment sequencer.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on each PIPG input; legal range 1..3.

Ports:
- CLOCK  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- STRT2  input  1  start/restart hold; synchronous, active-high; clears all pending requests.
- PIPSAM  input  1  sample enable; a pulse edge is accepted only while PIPSAM=1.
- PIPGXp, PIPGXm, PIPGYp, PIPGYm, PIPGZp, PIPGZm  input  1 each  gated PIPA pulse levels.
- CNTGNT  input  1  grant from counter sequencer; one-cycle pulse.
- CNTREQ  output  1  counter request valid.
- CNTADDR  output  2  axis of the request: 0=X, 1=Y, 2=Z; value 3 is never driven.
- CNTSGN  output  1  direction: 0=increment (+), 1=decrement (-).
- PIPAFAIL  output  1  sticky lost-pulse flag.

Behaviour:
- Reset (rst=1, asynchronous):
  - all synchroniser flops, edge registers and pending bits = 0;
  - CNTREQ=0, CNTADDR=0, CNTSGN=0, PIPAFAIL=0;
  - state = IDLE.
- Input path:
  - each PIPG input passes through SYNC_STAGES flops, then one edge-detect register;
  - a rising edge on the synchronised signal while PIPSAM=1 produces a one-cycle "hit";
  - edges seen while PIPSAM=0 are discarded and never recovered.
- Latency: an input rise with PIPSAM high sets its pending bit SYNC_STAGES+1 cycles later.
- Pending bits: six, named P[axis][sign].
  - A hit sets its bit.
  - A hit on an already-set bit that is not being granted this cycle keeps the bit at 1 and sets PIPAFAIL.
  - PIPAFAIL clears only on rst or STRT2.
- State machine:
  - IDLE:
    - Cancellation first: for each axis with both + and - pending, clear both bits; that axis is not eligible this cycle.
    - Then select the highest-priority remaining pending bit. Priority X+ > X- > Y+ > Y- > Z+ > Z-.
    - If one exists: register CNTADDR/CNTSGN and go to REQ (CNTREQ=1 from the next cycle).
  - REQ:
    - CNTREQ=1; CNTADDR/CNTSGN held stable.
    - New hits only update pending bits; they never change the presented request.
    - Cancellation is suppressed for the presented axis while in REQ.
    - On CNTGNT=1: clear the presented pending bit, CNTREQ=0 next cycle, go to IDLE.
  - CNTGNT while in IDLE is ignored.
- Minimum request spacing: 2 cycles (REQ, grant, IDLE, REQ).
- Simultaneous events:
  - Hit on the presented bit in its grant cycle: the bit stays set (the new pulse replaces the consumed one) and PIPAFAIL is not set.
  - Hits on several bits in one cycle: all are latched.
- STRT2=1:
  - next cycle, all pending bits, PIPAFAIL and CNTREQ = 0; state = IDLE;
  - synchronisers keep running; hits are ignored while STRT2=1;
  - if a request was in flight, it is dropped without waiting for grant.
- rst asserted mid-handshake: immediate return to reset values; a later CNTGNT is ignored.

Optional Feature:
- Macro: PIPA_LOST_COUNT_EN.
- Defined:
  - adds output port PIPALOST [7:0], a saturating count of lost pulses;
  - increments on every event that sets PIPAFAIL, including repeats while PIPAFAIL is already 1;
  - saturates at 255;
  - clears on rst or STRT2.
- Not defined: port absent; PIPAFAIL is the only loss indication.

Test Plan:
1. Reset, SYNC_STAGES=2, PIPSAM=1, single PIPGXp pulse at cycle 10 -> pending set at cycle 13, CNTREQ=1 with CNTADDR=0, CNTSGN=0 at cycle 14; CNTGNT at cycle 16 -> CNTREQ=0 at cycle 17, PIPAFAIL=0.
2. PIPGYm and PIPGZp rise the same cycle; grant each REQ immediately -> requests in order (1,1) then (2,0), spaced 2 cycles apart.
3. PIPGXp and PIPGXm both pending while in IDLE, no other inputs -> both cleared, CNTREQ never asserts.
4. Two PIPGZm pulses 4 cycles apart, CNTGNT withheld -> PIPAFAIL=1 after the second hit; with PIPA_LOST_COUNT_EN, PIPALOST=1; 300 further lost pulses -> PIPALOST=255.
5. PIPGXp edge while PIPSAM=0 -> no pending bit, no CNTREQ.
6. CNTREQ=1 then STRT2 pulsed 1 cycle -> CNTREQ=0 and PIPAFAIL=0 next cycle; later CNTGNT ignored. Repeat with rst instead of STRT2 -> outputs zero immediately.

Source files
------------

// File: rtl/pipa_cell_request_if.sv
// rtl/pipa_cell_request_if.sv - counter request/grant handshake between PIPA cell request and counter sequencer
interface pipa_cell_request_if;
  logic       CNTREQ;
  logic [1:0] CNTADDR;
  logic       CNTSGN;
  logic       CNTGNT;

  modport master (output CNTREQ, output CNTADDR, output CNTSGN, input CNTGNT);
  modport slave  (input CNTREQ, input CNTADDR, input CNTSGN, output CNTGNT);
endinterface

// File: rtl/pipa_cell_request.sv
// rtl/pipa_cell_request.sv - PIPA pulse to counter-cell request serialiser (optional PIPA_LOST_COUNT_EN adds PIPALOST)
module pipa_cell_request #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLOCK,
  input  logic                 rst,
  input  logic                 STRT2,
  input  logic                 PIPSAM,
  input  logic                 PIPGXp,
  input  logic                 PIPGXm,
  input  logic                 PIPGYp,
  input  logic                 PIPGYm,
  input  logic                 PIPGZp,
  input  logic                 PIPGZm,
  pipa_cell_request_if.master  cnt,
`ifdef PIPA_LOST_COUNT_EN
  output logic [7:0]           PIPALOST,
`endif
  output logic                 PIPAFAIL
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // Bit order is priority order: 0=X+ 1=X- 2=Y+ 3=Y- 4=Z+ 5=Z-
  logic [5:0] pipg;
  logic [5:0] sync_q [SYNC_STAGES];
  logic [5:0] edge_q;
  logic [5:0] hit;
  logic [5:0] pend, pend_n;
  logic [5:0] loss;
  logic [5:0] avail;
  logic [0:0] state, state_n;
  logic [1:0] addr, addr_n;
  logic       sgn, sgn_n;
  logic       fail_n;
  logic       granting;
  logic [2:0] cur_idx;
  logic [2:0] sel;
  logic       found;

  assign pipg        = {PIPGZm, PIPGZp, PIPGYm, PIPGYp, PIPGXm, PIPGXp};
  assign cur_idx     = {addr, sgn};
  assign granting    = (state == ST_REQ) && cnt.CNTGNT;
  assign hit         = sync_q[SYNC_STAGES-1] & ~edge_q & {6{PIPSAM & ~STRT2}};
  assign cnt.CNTREQ  = (state == ST_REQ);
  assign cnt.CNTADDR = addr;
  assign cnt.CNTSGN  = sgn;

  // Synchroniser chain and edge register; these keep running during STRT2
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= pipg;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Next-state: grant, axis cancellation, priority select, then hit latching
  always_comb begin
    pend_n  = pend;
    state_n = state;
    addr_n  = addr;
    sgn_n   = sgn;
    fail_n  = PIPAFAIL;
    loss    = '0;
    avail   = pend;
    sel     = '0;
    found   = 1'b0;
    if (STRT2) begin
      pend_n  = '0;
      fail_n  = 1'b0;
      state_n = ST_IDLE;
    end else begin
      if (granting) begin
        pend_n[cur_idx] = 1'b0;
        state_n         = ST_IDLE;
      end
      // Opposite pulses on one axis net to zero, except on the axis being presented
      for (int a = 0; a < 3; a++) begin
        if (pend[2*a] && pend[2*a+1] && !((state == ST_REQ) && (addr == 2'(a)))) begin
          pend_n[2*a]   = 1'b0;
          pend_n[2*a+1] = 1'b0;
          avail[2*a]    = 1'b0;
          avail[2*a+1]  = 1'b0;
        end
      end
      if (state == ST_IDLE) begin
        for (int i = 5; i >= 0; i--) begin
          if (avail[i]) begin
            sel   = 3'(i);
            found = 1'b1;
          end
        end
        if (found) begin
          state_n = ST_REQ;
          addr_n  = sel[2:1];
          sgn_n   = sel[0];
        end
      end
      // A hit on a still-pending bit loses a pulse unless that bit is consumed now
      for (int i = 0; i < 6; i++) begin
        if (hit[i]) begin
          if (pend[i] && !(granting && (cur_idx == 3'(i)))) loss[i] = 1'b1;
          pend_n[i] = 1'b1;
        end
      end
      if (|loss) fail_n = 1'b1;
    end
  end

  // Control and pending state registers
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      state    <= ST_IDLE;
      addr     <= '0;
      sgn      <= 1'b0;
      PIPAFAIL <= 1'b0;
    end else begin
      pend     <= pend_n;
      state    <= state_n;
      addr     <= addr_n;
      sgn      <= sgn_n;
      PIPAFAIL <= fail_n;
    end
  end

`ifdef PIPA_LOST_COUNT_EN
  logic [3:0] loss_num;
  logic [8:0] lost_sum;

  assign lost_sum = {1'b0, PIPALOST} + {5'd0, loss_num};

  // Number of pulses lost this cycle
  always_comb begin
    loss_num = '0;
    for (int i = 0; i < 6; i++) loss_num = loss_num + {3'd0, loss[i]};
  end

  // Saturating lost-pulse counter
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst)            PIPALOST <= '0;
    else if (STRT2)     PIPALOST <= '0;
    else if (lost_sum[8]) PIPALOST <= 8'hFF;
    else                PIPALOST <= lost_sum[7:0];
  end
`endif

endmodule
